// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Combinational lookup for IF, EX-stage training, misprediction detection and statistics.
module bpu_btb #(
  parameter int ENTRIES   = 64,
  parameter int TAG_W     = 8,
  parameter int CNT_W     = 2,
  parameter int PRED_MODE = 1,
  parameter int WR_BYPASS = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_hit,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_upd_vld,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_is_br,
  input  logic        i_upd_is_jmp,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_pred_taken,
  input  logic [31:0] i_upd_pred_target,
  output logic        o_mispred,
  output logic [31:0] o_fix_pc,
  input  logic        i_flush,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_ONE << (CNT_W - 1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd;
  logic             upd_hit;

  logic             wr_en;
  logic [31:0]      wr_target;
  logic [CNT_W-1:0] wr_cnt;

  logic             lk_valid;
  logic [TAG_W-1:0] lk_tag;
  logic [31:0]      lk_target;
  logic [CNT_W-1:0] lk_cnt;
  logic             bypass;

  logic [31:0] br_cnt_q;
  logic [31:0] mispred_cnt_q;

  assign if_idx  = i_if_pc[IDX_W+1:2];
  assign if_tag  = i_if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = i_upd_pc[IDX_W+1:2];
  assign upd_tag = i_upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  assign upd     = i_upd_vld & (i_upd_is_br | i_upd_is_jmp);
  assign upd_hit = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);

  // Training decision; reset and flush both suppress the write entirely
  always_comb begin
    wr_en     = 1'b0;
    wr_target = target_q[upd_idx];
    wr_cnt    = cnt_q[upd_idx];
    if (upd && !i_flush && !i_rst) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (i_upd_is_jmp) begin
          wr_cnt    = CNT_MAX;
          wr_target = i_upd_target;
        end else if (i_upd_taken) begin
          wr_cnt    = (cnt_q[upd_idx] == CNT_MAX) ? CNT_MAX : cnt_q[upd_idx] + CNT_ONE;
          wr_target = i_upd_target;
        end else begin
          wr_cnt = (cnt_q[upd_idx] == '0) ? '0 : cnt_q[upd_idx] - CNT_ONE;
        end
      end else if (i_upd_taken) begin
        wr_en     = 1'b1;
        wr_target = i_upd_target;
        wr_cnt    = i_upd_is_jmp ? CNT_MAX : CNT_WEAK;
      end
    end
  end

  assign bypass = (WR_BYPASS != 0) && wr_en && (upd_idx == if_idx);

  always_comb begin
    lk_valid  = valid_q[if_idx];
    lk_tag    = tag_q[if_idx];
    lk_target = target_q[if_idx];
    lk_cnt    = cnt_q[if_idx];
    if (bypass) begin
      lk_valid  = 1'b1;
      lk_tag    = upd_tag;
      lk_target = wr_target;
      lk_cnt    = wr_cnt;
    end
  end

  assign o_pred_hit    = lk_valid & (lk_tag == if_tag);
  assign o_pred_taken  = (PRED_MODE != 0) & o_pred_hit & lk_cnt[CNT_W-1];
  assign o_pred_target = o_pred_taken ? lk_target : i_if_pc + 32'd4;

  assign o_mispred = upd & ((i_upd_pred_taken != i_upd_taken) |
                            (i_upd_taken & (i_upd_pred_target != i_upd_target)));
  assign o_fix_pc  = i_upd_taken ? i_upd_target : i_upd_pc + 32'd4;

  // Valid bits and statistics; a flushed update is dropped from the stats as well
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q       <= '0;
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (i_flush) begin
        valid_q <= '0;
      end else if (wr_en) begin
        valid_q[upd_idx] <= 1'b1;
      end
      if (upd && !i_flush && (br_cnt_q != 32'hFFFF_FFFF)) begin
        br_cnt_q <= br_cnt_q + 32'd1;
      end
      if (o_mispred && !i_flush && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= wr_target;
      cnt_q[upd_idx]    <= wr_cnt;
    end
  end

  assign o_br_cnt      = br_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_bpu_btb.sv
// Bench for bpu_btb: three instances (bimodal, static+bypass, bimodal+bypass) compared
// every cycle against a table model, plus directed literal expectations.
module tb_bpu_btb;

  localparam int ENT = 64;
  localparam int NI  = 3;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        upd_vld;
  logic [31:0] upd_pc;
  logic        is_br;
  logic        is_jmp;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        pred_taken_in;
  logic [31:0] pred_target_in;
  logic        flush;

  logic        hit        [NI];
  logic        taken      [NI];
  logic [31:0] target     [NI];
  logic        mispred    [NI];
  logic [31:0] fix_pc     [NI];
  logic [31:0] br_cnt     [NI];
  logic [31:0] mis_cnt    [NI];

  int nChecks = 0;
  int nFail   = 0;
  bit checking = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    bpu_btb #(
      .ENTRIES  (ENT),
      .TAG_W    (8),
      .CNT_W    (2),
      .PRED_MODE((g == 1) ? 0 : 1),
      .WR_BYPASS((g == 0) ? 0 : 1)
    ) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_if_pc          (if_pc),
      .o_pred_hit       (hit[g]),
      .o_pred_taken     (taken[g]),
      .o_pred_target    (target[g]),
      .i_upd_vld        (upd_vld),
      .i_upd_pc         (upd_pc),
      .i_upd_is_br      (is_br),
      .i_upd_is_jmp     (is_jmp),
      .i_upd_taken      (upd_taken),
      .i_upd_target     (upd_target),
      .i_upd_pred_taken (pred_taken_in),
      .i_upd_pred_target(pred_target_in),
      .o_mispred        (mispred[g]),
      .o_fix_pc         (fix_pc[g]),
      .i_flush          (flush),
      .o_br_cnt         (br_cnt[g]),
      .o_mispred_cnt    (mis_cnt[g])
    );
  end

  initial clk = 0;
  always #5 clk = ~clk;

  // Model of the table: one row of entries per instance
  bit          mv   [NI][ENT];
  int          mtag [NI][ENT];
  logic [31:0] mtgt [NI][ENT];
  int          mcnt [NI][ENT];
  longint      mbr  [NI];
  longint      mmis [NI];

  function automatic bit modeBimodal(input int k);
    return k != 1;
  endfunction

  function automatic bit modeBypass(input int k);
    return k != 0;
  endfunction

  function automatic int idxOf(input logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic int tagOf(input logic [31:0] pc);
    return int'((pc >> 8) % 256);
  endfunction

  function automatic bit updActive();
    return upd_vld && (is_br || is_jmp);
  endfunction

  function automatic bit expMispred();
    return updActive() && ((pred_taken_in != upd_taken) ||
                           (upd_taken && pred_target_in != upd_target));
  endfunction

  function automatic void modelNext(input int k, output bit we, output int ntag,
                                    output logic [31:0] ntgt, output int ncnt);
    int i;
    bit h;
    i    = idxOf(upd_pc);
    h    = mv[k][i] && (mtag[k][i] == tagOf(upd_pc));
    we   = 0;
    ntag = tagOf(upd_pc);
    ntgt = mtgt[k][i];
    ncnt = mcnt[k][i];
    if (!updActive() || flush || rst) return;
    if (h) begin
      we = 1;
      if (is_jmp) begin
        ncnt = 3;
        ntgt = upd_target;
      end else if (upd_taken) begin
        ncnt = (ncnt + 1 > 3) ? 3 : ncnt + 1;
        ntgt = upd_target;
      end else begin
        ncnt = (ncnt - 1 < 0) ? 0 : ncnt - 1;
      end
    end else if (upd_taken) begin
      we   = 1;
      ntgt = upd_target;
      ncnt = is_jmp ? 3 : 2;
    end
  endfunction

  function automatic void modelLookup(input int k, output bit eh, output bit et,
                                      output logic [31:0] eg);
    int i, t, c, nt, nc;
    bit v, we;
    logic [31:0] g, ng;
    i = idxOf(if_pc);
    v = mv[k][i];
    t = mtag[k][i];
    g = mtgt[k][i];
    c = mcnt[k][i];
    if (modeBypass(k)) begin
      modelNext(k, we, nt, ng, nc);
      if (we && idxOf(upd_pc) == i) begin
        v = 1;
        t = nt;
        g = ng;
        c = nc;
      end
    end
    eh = v && (t == tagOf(if_pc));
    et = modeBimodal(k) && eh && (c >= 2);
    eg = et ? g : if_pc + 32'd4;
  endfunction

  always @(posedge clk) begin
    bit we;
    int nt, nc;
    logic [31:0] ng;
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        for (int i = 0; i < ENT; i++) mv[k][i] <= 0;
        mbr[k]  <= 0;
        mmis[k] <= 0;
      end else begin
        modelNext(k, we, nt, ng, nc);
        if (updActive() && !flush) begin
          mbr[k] <= mbr[k] + 1;
          if (expMispred()) mmis[k] <= mmis[k] + 1;
        end
        if (flush) begin
          for (int i = 0; i < ENT; i++) mv[k][i] <= 0;
        end else if (we) begin
          mv[k][idxOf(upd_pc)]   <= 1;
          mtag[k][idxOf(upd_pc)] <= nt;
          mtgt[k][idxOf(upd_pc)] <= ng;
          mcnt[k][idxOf(upd_pc)] <= nc;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int inst,
                             input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s[%0d]: got %h expected %h", name, inst, act, exp);
    end
  endtask

  // Every cycle, all instances against the model
  always @(negedge clk) begin
    bit eh, et;
    logic [31:0] eg;
    if (checking) begin
      for (int k = 0; k < NI; k++) begin
        modelLookup(k, eh, et, eg);
        checkOutput("model_hit", k, 32'(hit[k]), 32'(eh));
        checkOutput("model_taken", k, 32'(taken[k]), 32'(et));
        checkOutput("model_target", k, target[k], eg);
        checkOutput("model_mispred", k, 32'(mispred[k]), 32'(expMispred()));
        checkOutput("model_fix_pc", k, fix_pc[k], upd_taken ? upd_target : upd_pc + 32'd4);
        checkOutput("model_br_cnt", k, br_cnt[k], 32'(mbr[k]));
        checkOutput("model_mis_cnt", k, mis_cnt[k], 32'(mmis[k]));
      end
    end
  end

  task automatic applyStimulus(input bit r, input bit f, input bit v, input bit br,
                               input bit jmp, input bit tk, input logic [31:0] pc,
                               input logic [31:0] upc, input logic [31:0] tgt,
                               input bit ptk, input logic [31:0] ptgt);
    @(posedge clk);
    #1;
    rst            = r;
    flush          = f;
    upd_vld        = v;
    is_br          = br;
    is_jmp         = jmp;
    upd_taken      = tk;
    if_pc          = pc;
    upd_pc         = upc;
    upd_target     = tgt;
    pred_taken_in  = ptk;
    pred_target_in = ptgt;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] pc);
    applyStimulus(0, 0, 0, 0, 0, 0, pc, 32'h0, 32'h0, 0, 32'h0);
  endtask

  bit seqTaken [9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
  bit seqExp   [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};

  initial begin
    rst = 1; flush = 0; upd_vld = 0; is_br = 0; is_jmp = 0; upd_taken = 0;
    if_pc = 0; upd_pc = 0; upd_target = 0; pred_taken_in = 0; pred_target_in = 0;

    applyStimulus(1, 0, 0, 0, 0, 0, 32'h100, 32'h0, 32'h0, 0, 32'h0);
    checking = 1;
    checkOutput("rst_hit", 0, 32'(hit[0]), 32'd0);
    checkOutput("rst_taken", 0, 32'(taken[0]), 32'd0);
    checkOutput("rst_target", 0, target[0], 32'h104);
    checkOutput("rst_br_cnt", 0, br_cnt[0], 32'd0);
    checkOutput("rst_mis_cnt", 0, mis_cnt[0], 32'd0);

    applyStimulus(0, 0, 1, 1, 0, 1, 32'h100, 32'h100, 32'h80, 0, 32'h0);
    checkOutput("alloc_mispred", 0, 32'(mispred[0]), 32'd1);
    checkOutput("alloc_fix_pc", 0, fix_pc[0], 32'h80);
    idle(32'h100);
    checkOutput("alloc_hit", 0, 32'(hit[0]), 32'd1);
    checkOutput("alloc_taken", 0, 32'(taken[0]), 32'd1);
    checkOutput("alloc_target", 0, target[0], 32'h80);
    checkOutput("alloc_mis_cnt", 0, mis_cnt[0], 32'd1);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 0, 1, 1, 0, seqTaken[i], 32'h100, 32'h100, 32'h80,
                    seqTaken[i], 32'h80);
      idle(32'h100);
      checkOutput("sat_taken", i, 32'(taken[0]), 32'(seqExp[i]));
      checkOutput("sat_target", i, target[0], seqExp[i] ? 32'h80 : 32'h104);
    end

    applyStimulus(0, 0, 1, 1, 0, 1, 32'h100, 32'h200, 32'h300, 1, 32'h300);
    checkOutput("alias_pre_hit", 0, 32'(hit[0]), 32'd1);
    idle(32'h100);
    checkOutput("alias_evict_hit", 0, 32'(hit[0]), 32'd0);
    idle(32'h200);
    checkOutput("alias_new_hit", 0, 32'(hit[0]), 32'd1);
    checkOutput("alias_new_target", 0, target[0], 32'h300);

    applyStimulus(0, 1, 1, 1, 0, 1, 32'h200, 32'h200, 32'h400, 0, 32'h0);
    checkOutput("flush_mispred", 0, 32'(mispred[0]), 32'd1);
    idle(32'h200);
    checkOutput("flush_hit", 0, 32'(hit[0]), 32'd0);
    checkOutput("flush_br_cnt", 0, br_cnt[0], 32'd11);
    checkOutput("flush_mis_cnt", 0, mis_cnt[0], 32'd1);

    applyStimulus(0, 0, 1, 1, 0, 1, 32'h140, 32'h140, 32'h500, 1, 32'h500);
    checkOutput("byp_hit", 0, 32'(hit[0]), 32'd0);
    checkOutput("byp_hit", 1, 32'(hit[1]), 32'd1);
    checkOutput("byp_taken", 1, 32'(taken[1]), 32'd0);
    checkOutput("byp_target", 1, target[1], 32'h144);
    checkOutput("byp_hit", 2, 32'(hit[2]), 32'd1);
    checkOutput("byp_taken", 2, 32'(taken[2]), 32'd1);
    checkOutput("byp_target", 2, target[2], 32'h500);
    idle(32'h140);
    checkOutput("static_hit", 1, 32'(hit[1]), 32'd1);
    checkOutput("static_taken", 1, 32'(taken[1]), 32'd0);
    checkOutput("static_target", 1, target[1], 32'h144);
    checkOutput("post_target", 0, target[0], 32'h500);

    applyStimulus(1, 0, 1, 1, 0, 1, 32'h180, 32'h180, 32'h600, 0, 32'h0);
    idle(32'h180);
    checkOutput("rst_drop_hit", 0, 32'(hit[0]), 32'd0);
    checkOutput("rst_drop_br_cnt", 0, br_cnt[0], 32'd0);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pcA, pcB, tg, pt;
      bit r, f, v, br, jmp, tk, ptk;
      pcA = 32'(($urandom_range(0, 2) + 1) << 8) | 32'($urandom_range(0, 7) << 2);
      pcB = 32'(($urandom_range(0, 2) + 1) << 8) | 32'($urandom_range(0, 7) << 2);
      tg  = 32'h1000 + 32'($urandom_range(0, 3) << 2);
      pt  = ($urandom_range(0, 1) == 1) ? tg : 32'h1000 + 32'($urandom_range(0, 3) << 2);
      r   = ($urandom_range(0, 399) == 0);
      f   = ($urandom_range(0, 49) == 0);
      v   = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 2) != 0);
      jmp = ($urandom_range(0, 3) == 0);
      tk  = jmp ? 1'b1 : 1'($urandom_range(0, 1));
      ptk = 1'($urandom_range(0, 1));
      applyStimulus(r, f, v, br, jmp, tk, ($urandom_range(0, 3) == 0) ? pcB : pcA,
                    pcB, tg, ptk, pt);
    end

    @(posedge clk);
    #1;
    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
